// File: rtl/read_response_buffer.sv
// read_response_buffer: in-order read-response buffer with credit-based issue.
// Credits guarantee that every response has a slot, so the return path is
// never back-pressured. A clear drops buffered words and squashes every
// response still in flight.
// Optional feature: define READ_RESPONSE_BUFFER_BYPASS_EN to forward a
// response straight to the head output when the buffer is empty.
//
// Handshake: issue is a one-sided notification that memory accepted a
// request this cycle; it takes a credit only when issue_ready is high.
// read_data_valid cannot be stalled. pop consumes the head only when
// head_valid is high; pop on an empty head is ignored.
module read_response_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  issue,
  output logic                  issue_ready,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  read_data_valid,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      outstanding,
  output logic                  error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_W + 2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] squash_q, squash_d;
  logic             head_valid_q, head_valid_d;
  logic             error_q, error_d;

  logic [SUM_W-1:0] credit_sum;
  logic             issue_acc;
  logic             resp_squash;
  logic             resp_live;
  logic             resp_err;
  logic             pop_acc;
  logic             bypass_hit;
  logic             bypass_consume;
  logic             write_en;

  // Credit check uses registered counters only, so issue_ready has no
  // combinational dependence on this cycle's inputs.
  always_comb begin
    credit_sum  = SUM_W'(count_q) + SUM_W'(outstanding_q) + SUM_W'(squash_q);
    issue_ready = (credit_sum < SUM_W'(DEPTH));
  end

  // Classify this cycle's events; squashed responses always come first
  // because responses return in issue order.
  always_comb begin
    issue_acc   = issue && issue_ready;
    resp_squash = read_data_valid && (squash_q != '0);
    resp_live   = read_data_valid && (squash_q == '0) && (outstanding_q != '0);
    resp_err    = read_data_valid && (squash_q == '0) && (outstanding_q == '0);
    pop_acc     = pop && head_valid_q && !clear;
  end

`ifdef READ_RESPONSE_BUFFER_BYPASS_EN
  // Empty buffer: a live response is presented at the head immediately;
  // if the consumer pops in the same cycle the word never gets stored.
  always_comb begin
    bypass_hit     = (count_q == '0) && resp_live && !clear;
    bypass_consume = bypass_hit && pop;
  end
`else
  // No forwarding: responses reach the head only through storage.
  always_comb begin
    bypass_hit     = 1'b0;
    bypass_consume = 1'b0;
  end
`endif

  // Next-state for pointers, counters and the sticky error flag.
  always_comb begin
    write_en      = resp_live && !clear && !bypass_consume;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    squash_d      = squash_q;
    error_d       = error_q || (issue && !issue_ready) || resp_err;

    if (clear) begin
      // Everything issued before the clear becomes squash; a response in
      // this cycle is pre-clear and retires one of those immediately.
      rd_ptr_d      = wr_ptr_q;
      count_d       = '0;
      outstanding_d = CNT_W'(issue_acc);
      squash_d      = squash_q + outstanding_q
                      - CNT_W'(resp_squash || resp_live);
    end else begin
      if (write_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d       = count_q + CNT_W'(write_en) - CNT_W'(pop_acc);
      outstanding_d = outstanding_q + CNT_W'(issue_acc) - CNT_W'(resp_live);
      squash_d      = squash_q - CNT_W'(resp_squash);
    end

    head_valid_d = (count_d != '0);
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      squash_q      <= '0;
      head_valid_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      squash_q      <= squash_d;
      head_valid_q  <= head_valid_d;
      error_q       <= error_d;
    end
  end

  // Storage array write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!reset && write_en) begin
      mem_q[wr_ptr_q] <= read_data;
    end
  end

  // Head output: stored entry at the read pointer, zero when empty, or the
  // forwarded response word when bypassing.
  always_comb begin
    head_valid = head_valid_q || bypass_hit;
    if (bypass_hit) begin
      head_data = read_data;
    end else if (head_valid_q) begin
      head_data = mem_q[rd_ptr_q];
    end else begin
      head_data = '0;
    end
  end

  // Counter and flag outputs.
  always_comb begin
    count       = count_q;
    outstanding = outstanding_q;
    error       = error_q;
  end

endmodule

// File: tb/tb_read_response_buffer.sv
// Directed testbench for read_response_buffer (DATA_WIDTH=32, DEPTH=4).
module tb_read_response_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic          clk;
  logic          reset;
  logic          clear;
  logic          issue;
  logic          issue_ready;
  logic [DW-1:0] read_data;
  logic          read_data_valid;
  logic          pop;
  logic [DW-1:0] head_data;
  logic          head_valid;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] outstanding;
  logic          error;

  int checks;
  int errors;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_w;

  read_response_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .clear           (clear),
    .issue           (issue),
    .issue_ready     (issue_ready),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .pop             (pop),
    .head_data       (head_data),
    .head_valid      (head_valid),
    .count           (count),
    .outstanding     (outstanding),
    .error           (error)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear           = 1'b0;
    issue           = 1'b0;
    read_data_valid = 1'b0;
    read_data       = '0;
    pop             = 1'b0;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    do_reset();

    // reset values
    check("rst_count", DW'(count), 0);
    check("rst_outstanding", DW'(outstanding), 0);
    check("rst_head_valid", DW'(head_valid), 0);
    check("rst_head_data", head_data, 0);
    check("rst_issue_ready", DW'(issue_ready), 1);
    check("rst_error", DW'(error), 0);

    // fill to DEPTH, then drain in order
    issue = 1'b1;
    for (int i = 0; i < 4; i++) step();
    issue = 1'b0;
    check("fill_outstanding", DW'(outstanding), 4);
    check("fill_ready_credits", DW'(issue_ready), 0);
    read_data_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      read_data = 32'hA0 + DW'(i);
      exp_q.push_back(read_data);
      step();
    end
    read_data_valid = 1'b0;
    check("fill_count", DW'(count), 4);
    check("fill_ready_full", DW'(issue_ready), 0);
    for (int i = 0; i < 4; i++) begin
      exp_w = exp_q.pop_front();
      check("drain_head_valid", DW'(head_valid), 1);
      check("drain_head_data", head_data, exp_w);
      pop = 1'b1;
      step();
      pop = 1'b0;
      if (i == 0) check("ready_after_pop", DW'(issue_ready), 1);
    end
    check("drain_count", DW'(count), 0);
    check("drain_head_valid_end", DW'(head_valid), 0);

    // clear with in-flight responses plus a same-cycle issue
    issue = 1'b1;
    for (int i = 0; i < 3; i++) step();
    issue = 1'b0;
    read_data_valid = 1'b1;
    read_data = 32'h11;
    step();
    read_data_valid = 1'b0;
    check("pre_clear_count", DW'(count), 1);
    check("pre_clear_outstanding", DW'(outstanding), 2);
    clear = 1'b1;
    issue = 1'b1;
    step();
    idle();
    check("clear_count", DW'(count), 0);
    check("clear_outstanding", DW'(outstanding), 1);
    check("clear_head_valid", DW'(head_valid), 0);
    read_data_valid = 1'b1;
    read_data = 32'h22;
    step();
    check("squash1_count", DW'(count), 0);
    read_data = 32'h33;
    step();
    check("squash2_count", DW'(count), 0);
    check("squash2_head_valid", DW'(head_valid), 0);
    read_data = 32'h44;
    step();
    read_data_valid = 1'b0;
    check("live_count", DW'(count), 1);
    check("live_head_data", head_data, 32'h44);
    check("live_outstanding", DW'(outstanding), 0);
    check("clear_error", DW'(error), 0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("live_drained", DW'(count), 0);

    // pointer wrap: stream with simultaneous response and pop
    issue = 1'b1;
    step();
    step();
    issue = 1'b0;
    read_data_valid = 1'b1;
    read_data = 32'hB00;
    step();
    read_data_valid = 1'b0;
    check("prefill_count", DW'(count), 1);
    check("prefill_head", head_data, 32'hB00);
    for (int i = 0; i < 10; i++) begin
      issue = 1'b1;
      read_data_valid = 1'b1;
      pop = 1'b1;
      read_data = 32'hB01 + DW'(i);
      exp_w = read_data;
      step();
      check("stream_count", DW'(count), 1);
      check("stream_head", head_data, exp_w);
    end
    issue = 1'b0;
    read_data = 32'hBFF;
    step();
    idle();
    check("stream_tail_head", head_data, 32'hBFF);
    check("stream_tail_outstanding", DW'(outstanding), 0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("stream_empty", DW'(count), 0);
    check("stream_error", DW'(error), 0);

    // protocol violations
    read_data_valid = 1'b1;
    read_data = 32'hDEAD;
    step();
    read_data_valid = 1'b0;
    check("stray_resp_error", DW'(error), 1);
    check("stray_resp_count", DW'(count), 0);
    check("stray_resp_outstanding", DW'(outstanding), 0);
    issue = 1'b1;
    for (int i = 0; i < 5; i++) step();
    issue = 1'b0;
    check("overissue_outstanding", DW'(outstanding), 4);
    check("overissue_count", DW'(count), 0);
    check("overissue_error", DW'(error), 1);
    step();
    check("error_sticky", DW'(error), 1);
    do_reset();
    check("reset_clears_error", DW'(error), 0);
    check("reset_outstanding", DW'(outstanding), 0);

    // response arriving in the clear cycle is discarded
    issue = 1'b1;
    step();
    issue = 1'b0;
    clear = 1'b1;
    read_data_valid = 1'b1;
    read_data = 32'h55;
    step();
    idle();
    check("clr_resp_count", DW'(count), 0);
    check("clr_resp_head_valid", DW'(head_valid), 0);
    check("clr_resp_outstanding", DW'(outstanding), 0);
    // zero squash means all DEPTH credits are available again
    issue = 1'b1;
    for (int i = 0; i < 4; i++) step();
    issue = 1'b0;
    check("clr_resp_credits", DW'(outstanding), 4);
    read_data_valid = 1'b1;
    read_data = 32'h66;
    step();
    read_data_valid = 1'b0;
    check("clr_resp_next_head", head_data, 32'h66);
    check("clr_resp_error", DW'(error), 0);

`ifdef READ_RESPONSE_BUFFER_BYPASS_EN
    // bypass: same-cycle forward and consume from empty
    do_reset();
    issue = 1'b1;
    step();
    issue = 1'b0;
    read_data_valid = 1'b1;
    read_data = 32'h77;
    pop = 1'b1;
    #1;
    check("bypass_head_valid", DW'(head_valid), 1);
    check("bypass_head_data", head_data, 32'h77);
    step();
    idle();
    check("bypass_count", DW'(count), 0);
    check("bypass_outstanding", DW'(outstanding), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/read_response_buffer.md
# read_response_buffer

Parametrised in-order read-response buffer for the CPU memory read path. It sits between the memory read-data return and the fetch/load consumers. It issues credits for new read requests so that responses always have space and are never back-pressured. It queues up to DEPTH responses, and on `clear` it discards both the buffered data and every response still in flight.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one read response word
- DEPTH, 4, buffer entries and maximum in-flight reads; power of two, 2..16
- CNT_W (localparam), $clog2(DEPTH+1), width of all counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- clear  in  1  flush: drop buffered entries and squash in-flight responses
- issue  in  1  a read request was accepted by memory this cycle
- issue_ready  out  1  a credit is free; high iff count+outstanding+squash < DEPTH
- read_data  in  DATA_WIDTH  response word
- read_data_valid  in  1  response word valid this cycle
- pop  in  1  consumer takes the head entry
- head_data  out  DATA_WIDTH  oldest buffered word
- head_valid  out  1  head_data is meaningful
- count  out  CNT_W  number of buffered entries
- outstanding  out  CNT_W  live requests issued and not yet answered
- error  out  1  sticky protocol-violation flag

## Operation
- Storage is a DEPTH-entry circular array with log2(DEPTH)-bit read and write pointers, wrapping modulo DEPTH.
- squash counter (internal, CNT_W): pre-clear responses still to arrive.
- Responses return in issue order, so squashed responses always arrive before live ones.
- Accepted issue (issue && issue_ready): outstanding+1.
- issue && !issue_ready: ignored; error set.
- Response while squash>0: discarded; squash-1.
- Response while squash==0 and outstanding>0: written at the write pointer; write pointer+1, outstanding-1, count+1.
- Response while squash==0 and outstanding==0: discarded; error set.
- pop && head_valid: read pointer+1, count-1. pop while !head_valid: ignored, no error.
- Response and pop in the same cycle: both take effect; count is unchanged.
- clear:
  - Read pointer is set to the write pointer and count becomes 0.
  - squash becomes squash+outstanding, minus 1 if a response arrives the same cycle. That response is pre-clear and is discarded.
  - outstanding becomes 0, plus 1 if a new issue is accepted the same cycle. That request is post-clear and live.
  - pop in the same cycle is a no-op.
- Invariant: count+outstanding+squash ≤ DEPTH. Consequently the buffer never overflows.
- error is cleared only by reset.

## Timing
- Values on reset:
  - count, outstanding, squash, error: 0
  - read and write pointers: 0
  - head_valid: 0; head_data: 0
  - issue_ready: 1
- Storage array contents are not reset.
- head_valid = (count != 0), registered.
- head_data is read combinationally from the entry at the read pointer.
- Without bypass, a response accepted in cycle N is visible at head in cycle N+1 at the earliest.
- issue_ready is combinational from registered counters only. It never depends on the current cycle's inputs.
- A credit freed by pop in cycle N is visible on issue_ready in cycle N+1.

## Configuration
- Macro READ_RESPONSE_BUFFER_BYPASS_EN.
- When defined: if count==0 and a response is accepted (squash==0, outstanding>0, !clear), then in the same cycle head_valid=1 and head_data=read_data.
  - If pop is also high that cycle, the word is consumed. It is not stored, count is unchanged, and outstanding-1.
  - If pop is low, the word is stored as normal.
- When undefined: no combinational path from read_data or read_data_valid to the outputs; latency is as in Timing.

## Test plan
- Reset, then issue 4 reads with DEPTH=4. Return 0xA0..0xA3 on consecutive cycles, no pops. Expected:
  - count reaches 4; issue_ready=0.
  - Popping 4 times yields 0xA0,0xA1,0xA2,0xA3 in order.
  - issue_ready returns to 1 the cycle after the first pop.
- Issue 3 reads and return 1 (0x11). Then assert clear with 2 outstanding, and issue 1 new read the same cycle. Expected:
  - squash=2, outstanding=1, count=0.
  - Return 0x22, 0x33, 0x44: only 0x44 appears at head; error stays 0.
- Pointer wrap: stream 10 words with pop and response in the same cycle, after a 1-entry prefill. Expected: count stays 1, data order is preserved across the pointer wrap, and head_data matches each word one cycle later.
- Protocol violations: assert read_data_valid with outstanding=0 and squash=0, and assert issue while issue_ready=0. Expected: error=1 and it stays set; count and outstanding are unchanged. Assert reset: error=0.
- Simultaneous response and clear: 1 outstanding, response 0x55 arrives in the clear cycle. Expected: squash=0, count=0, and 0x55 never appears at head.
- Bypass, with READ_RESPONSE_BUFFER_BYPASS_EN defined: from empty, 1 outstanding, response 0x77 arrives with pop=1. Expected: head_valid=1 and head_data=0x77 in the same cycle; the next cycle count=0 and outstanding=0.
